// File: rtl/wb_pkg.sv
// Shared constants, types and helpers for the register-bank writeback stage.
// onehot() is also used by the bank's read-side decode.
package wb_pkg;

    localparam int DATA_W     = 16;
    localparam int NREGS      = 8;
    localparam int IDX_W      = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [IDX_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_FIFO,
        SRC_ALU
    } wb_src_t;

    function automatic logic [NREGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, issue port and register-bank drive of the writeback stage.
// The slave modport is the writeback block; master is whoever surrounds it.
interface regfile_writeback_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [IDX_W-1:0]  alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [IDX_W-1:0]  mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic              issue_valid;
    logic [IDX_W-1:0]  issue_dest;
    logic [NREGS-1:0]  en;
    logic [DATA_W-1:0] to_dest_reg;
    logic [NREGS-1:0]  busy;

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        input  issue_valid, issue_dest,
        output alu_ready, mem_ready, en, to_dest_reg, busy
    );

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        output issue_valid, issue_dest,
        input  alu_ready, mem_ready, en, to_dest_reg, busy
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering ALU results that lost arbitration.
// Push and pop in the same cycle keep occupancy unchanged; the caller never pushes when full.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wr_entry,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        next_ptr = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use <= so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == OCC_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: merges ALU and load results into one registered bank write per cycle
// and tracks a per-register busy scoreboard for RAW hazard detection.
module regfile_writeback
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    regfile_writeback_if.slave  wb
);

    wb_entry_t         head, alu_entry, mem_entry, win_entry;
    wb_src_t           src;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic              alu_ready, mem_ready, alu_acc, mem_acc;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [NREGS-1:0]  en_q, en_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] to_dest_reg_q, to_dest_reg_d;

    assign alu_entry = '{dest: wb.alu_dest, data: wb.alu_data};
    assign mem_entry = '{dest: wb.mem_dest, data: wb.mem_data};

    // Readiness depends only on state, never on the producers' valid.
    assign alu_ready = !fifo_full;
    assign mem_ready = (starve_cnt_q != CNT_W'(STARVE_MAX));
    assign alu_acc   = wb.alu_valid && alu_ready;
    assign mem_acc   = wb.mem_valid && mem_ready;

    always_comb begin
        src       = SRC_NONE;
        win_entry = head;
        if (mem_acc) begin
            src       = SRC_MEM;
            win_entry = mem_entry;
        end else if (!fifo_empty) begin
            src       = SRC_FIFO;
            win_entry = head;
        end else if (alu_acc) begin
            src       = SRC_ALU;
            win_entry = alu_entry;
        end
    end

    assign push = alu_acc && (src != SRC_ALU);
    assign pop  = (src == SRC_FIFO);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (alu_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    always_comb begin
        // Any cycle in which the FIFO pops or sits empty ends the starvation run.
        starve_cnt_d  = (src == SRC_MEM && !fifo_empty) ? starve_cnt_q + 1'b1 : '0;
        en_d          = '0;
        to_dest_reg_d = to_dest_reg_q;
        busy_d        = busy_q;
        if (src != SRC_NONE) begin
            en_d                   = onehot(win_entry.dest);
            to_dest_reg_d          = win_entry.data;
            busy_d[win_entry.dest] = 1'b0;
        end
        // Applied after the clear so a new writer issued on the same edge stays pending.
        if (wb.issue_valid) busy_d[wb.issue_dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q  <= '0;
            en_q          <= '0;
            to_dest_reg_q <= '0;
            busy_q        <= '0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            en_q          <= en_d;
            to_dest_reg_q <= to_dest_reg_d;
            busy_q        <= busy_d;
        end
    end

    assign wb.alu_ready   = alu_ready;
    assign wb.mem_ready   = mem_ready;
    assign wb.en          = en_q;
    assign wb.to_dest_reg = to_dest_reg_q;
    assign wb.busy        = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised and directed stimulus for regfile_writeback against a queue-based model;
// a negedge monitor pops expected bank writes and compares them with the DUT.
module tb_regfile_writeback;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic [7:0]  en;
        logic [15:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    regfile_writeback_if wb_if ();

    regfile_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    ent_t        alu_q[$];
    exp_t        exp_q[$];
    int          starve;
    logic [7:0]  m_busy;
    logic [15:0] last_data;
    bit          last_alu_acc, last_mem_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        alu_q.delete();
        exp_q.delete();
        starve       = 0;
        m_busy       = '0;
        last_data    = '0;
        last_alu_acc = 1'b0;
        last_mem_acc = 1'b0;
    endtask

    // One clock edge of the writeback rules, applied to the model.
    task automatic model_step();
        bit   a_rdy, m_rdy, a_acc, m_acc, had_entries, have;
        ent_t a, m, w;
        a_rdy       = (alu_q.size() < DEPTH);
        m_rdy       = (starve != STARVE);
        a_acc       = wb_if.alu_valid && a_rdy;
        m_acc       = wb_if.mem_valid && m_rdy;
        a           = '{wb_if.alu_dest, wb_if.alu_data};
        m           = '{wb_if.mem_dest, wb_if.mem_data};
        had_entries = (alu_q.size() != 0);
        have        = 1'b0;
        w           = '{3'd0, 16'd0};
        if (m_acc) begin
            w      = m;
            have   = 1'b1;
            starve = had_entries ? starve + 1 : 0;
            if (a_acc) alu_q.push_back(a);
        end else begin
            starve = 0;
            if (had_entries) begin
                w    = alu_q.pop_front();
                have = 1'b1;
                if (a_acc) alu_q.push_back(a);
            end else if (a_acc) begin
                w    = a;
                have = 1'b1;
            end
        end
        if (have) begin
            exp_q.push_back('{8'(1 << w.dest), w.data});
            last_data      = w.data;
            m_busy[w.dest] = 1'b0;
        end
        if (wb_if.issue_valid) m_busy[wb_if.issue_dest] = 1'b1;
        last_alu_acc = a_acc;
        last_mem_acc = m_acc;
    endtask

    // Called at posedge+1; drives inputs, checks readiness, then advances one edge.
    task automatic cycle(input logic av, input logic [2:0] ad, input logic [15:0] adat,
                         input logic mv, input logic [2:0] md, input logic [15:0] mdat,
                         input logic iv, input logic [2:0] id);
        wb_if.alu_valid   = av;
        wb_if.alu_dest    = ad;
        wb_if.alu_data    = adat;
        wb_if.mem_valid   = mv;
        wb_if.mem_dest    = md;
        wb_if.mem_data    = mdat;
        wb_if.issue_valid = iv;
        wb_if.issue_dest  = id;
        check("alu_ready", 32'(wb_if.alu_ready), 32'(alu_q.size() < DEPTH));
        check("mem_ready", 32'(wb_if.mem_ready), 32'(starve != STARVE));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 0, 3'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_clear();
        wb_if.alu_valid   = 1'b0;
        wb_if.mem_valid   = 1'b0;
        wb_if.issue_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_en", 32'(wb_if.en), 32'h0);
        check("rst_busy", 32'(wb_if.busy), 32'h0);
        check("rst_data", 32'(wb_if.to_dest_reg), 32'h0);
        check("rst_alu_ready", 32'(wb_if.alu_ready), 32'h1);
        check("rst_mem_ready", 32'(wb_if.mem_ready), 32'h1);
        rst_n = 1'b1;
    endtask

    // Monitor: one registered write per cycle, visible at the negedge after the winning edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_en", 32'(wb_if.en), 32'(e.en));
                check("wr_data", 32'(wb_if.to_dest_reg), 32'(e.data));
            end else begin
                check("idle_en", 32'(wb_if.en), 32'h0);
                check("hold_data", 32'(wb_if.to_dest_reg), 32'(last_data));
            end
            check("busy", 32'(wb_if.busy), 32'(m_busy));
        end
    end

    initial begin
        logic        r_av, r_mv, r_iv;
        logic [2:0]  r_ad, r_md, r_id;
        logic [15:0] r_adat, r_mdat;

        wb_if.alu_dest = '0;
        wb_if.alu_data = '0;
        wb_if.mem_dest = '0;
        wb_if.mem_data = '0;
        wb_if.issue_dest = '0;
        do_reset(3);

        // Uncontended ALU beat bypasses the empty FIFO
        cycle(1, 3'd1, 16'h0001, 0, 3'd0, 16'd0, 0, 3'd0);
        check("bypass_en", 32'(wb_if.en), 32'h02);
        check("bypass_data", 32'(wb_if.to_dest_reg), 32'h0001);
        idle(2);

        // Collision: load first, buffered ALU result next cycle
        cycle(1, 3'd3, 16'h5555, 1, 3'd2, 16'hAAAA, 0, 3'd0);
        check("coll_first_en", 32'(wb_if.en), 32'h04);
        check("coll_first_data", 32'(wb_if.to_dest_reg), 32'hAAAA);
        idle(1);
        check("coll_second_en", 32'(wb_if.en), 32'h08);
        check("coll_second_data", 32'(wb_if.to_dest_reg), 32'h5555);
        idle(2);

        // Back-pressure: both producers held valid with fixed payloads
        for (int i = 0; i < 10; i++) begin
            cycle(1, 3'd6, 16'h1234, 1, 3'd7, 16'hBEEF, 0, 3'd0);
            if (i == 2) check("bp_full", 32'(wb_if.alu_ready), 32'h0);
            if (i == 4) check("bp_starved", 32'(wb_if.mem_ready), 32'h0);
            if (i == 5) check("bp_head_en", 32'(wb_if.en), 32'h40);
        end
        idle(4);

        // Scoreboard set, same-edge set/clear, then clear
        cycle(0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 1, 3'd5);
        check("sb_set", 32'(wb_if.busy), 32'h20);
        cycle(1, 3'd5, 16'h0055, 0, 3'd0, 16'd0, 1, 3'd5);
        check("sb_set_wins", 32'(wb_if.busy), 32'h20);
        cycle(1, 3'd5, 16'h0066, 0, 3'd0, 16'd0, 0, 3'd0);
        check("sb_clear", 32'(wb_if.busy), 32'h00);
        cycle(0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 1, 3'd2);
        idle(10);

        // Randomised traffic honouring the hold-while-stalled rule
        r_av = 0; r_mv = 0;
        r_ad = '0; r_md = '0; r_adat = '0; r_mdat = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!(r_av && !last_alu_acc)) begin
                r_av   = ($urandom_range(0, 99) < 60);
                r_ad   = 3'($urandom);
                r_adat = 16'($urandom);
            end
            if (!(r_mv && !last_mem_acc)) begin
                r_mv   = ($urandom_range(0, 99) < 50);
                r_md   = 3'($urandom);
                r_mdat = 16'($urandom);
            end
            r_iv = ($urandom_range(0, 3) == 0);
            r_id = 3'($urandom);
            cycle(r_av, r_ad, r_adat, r_mv, r_md, r_mdat, r_iv, r_id);
        end
        idle(4);

        // Mid-run reset with the FIFO holding two entries
        cycle(0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 1, 3'd4);
        cycle(1, 3'd1, 16'h1111, 1, 3'd0, 16'h2222, 0, 3'd0);
        cycle(1, 3'd3, 16'h3333, 1, 3'd0, 16'h4444, 0, 3'd0);
        check("pre_rst_full", 32'(wb_if.alu_ready), 32'h0);
        do_reset(2);
        idle(3);

        check("drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
